hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the stall/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline buffers, plus PC hold and PC redirect.
- Arbitrates between three hazard sources: load-use interlock, taken-branch flush, and multi-cycle data-memory wait with timeout.

---
 rtl/hazard_pkg.sv | 7 +
 rtl/hazard_perf_cnt.sv | 15 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and default constants for the hazard sequencer.
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int FLUSH_CYCLES_DEF = 1;
  localparam int MEM_TIMEOUT_DEF = 255;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating 32-bit event counter with enable, sync active-low reset.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_cnt
);
  logic [31:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst) r_cnt <= '0;
    else if (i_en && r_cnt != 32'hFFFF_FFFF) r_cnt <= r_cnt + 32'd1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer arbitrating memory wait, branch flush and load-use.
// Define HAZARD_PERF_EN to add saturating perf counters perf_lu/perf_flush/perf_memwait.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        pc_redirect,
  output logic        if_stall,
  output logic        if_clear,
  output logic        id_stall,
  output logic        id_clear,
  output logic        ex_stall,
  output logic        ex_clear,
  output logic        mem_stall,
  output logic        mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_memwait
`endif
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t          r_state, w_state_nx;
  logic [2:0]      r_flush_cnt, w_flush_nx;
  logic [WW-1:0]   r_wait_cnt, w_wait_nx;
  logic            w_in_wait, w_mem_block, w_load_use, w_hold, w_timeout, w_br, w_fl, w_lu;
  always_comb begin
    w_in_wait   = r_state == MEM_WAIT;
    w_mem_block = mem_req && !mem_ready;
    w_load_use  = ex_MemRead && ex_rd != REG_ZERO &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    w_hold      = w_in_wait ? !mem_ready : w_mem_block;
    w_timeout   = w_in_wait && !mem_ready && r_wait_cnt == WW'(MEM_TIMEOUT);
    w_br        = !w_in_wait && !w_mem_block && branch_taken;
    w_fl        = r_state == FLUSH && !w_mem_block;
    w_lu        = r_state == RUN && !w_mem_block && !branch_taken && w_load_use;
  end
  assign pc_stall    = rst && (w_hold || w_lu);
  assign if_stall    = rst && (w_hold || w_lu);
  assign id_stall    = rst && w_hold;
  assign ex_stall    = rst && w_hold;
  assign mem_stall   = rst && w_hold;
  assign pc_redirect = rst && w_br;
  assign if_clear    = !rst || w_br || w_fl;
  assign id_clear    = !rst || w_br || w_fl || w_lu;
  assign ex_clear    = !rst || w_timeout;
  assign mem_err     = rst && w_timeout;
  // A held branch is ignored while waiting; the frozen EX stage re-presents it after exit.
  always_comb begin
    w_state_nx = r_state;
    w_flush_nx = r_flush_cnt;
    w_wait_nx  = r_wait_cnt;
    if (w_in_wait) begin
      w_state_nx = (mem_ready || w_timeout) ? RUN : MEM_WAIT;
      w_wait_nx  = (mem_ready || w_timeout) ? '0 : r_wait_cnt + WW'(1);
    end else if (w_mem_block) begin
      w_state_nx = MEM_WAIT;
      w_wait_nx  = WW'(1);
      w_flush_nx = '0;
    end else if (branch_taken) begin
      w_state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      w_flush_nx = 3'(FLUSH_CYCLES - 1);
    end else if (r_state == FLUSH) begin
      w_state_nx = r_flush_cnt <= 3'd1 ? RUN : FLUSH;
      w_flush_nx = r_flush_cnt <= 3'd1 ? 3'd0 : r_flush_cnt - 3'd1;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_flush_cnt <= w_flush_nx;
      r_wait_cnt  <= w_wait_nx;
    end
`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf_lu (.clk(clk), .rst(rst), .i_en(w_lu), .o_cnt(perf_lu));
  hazard_perf_cnt u_perf_flush (.clk(clk), .rst(rst), .i_en(w_br || w_fl), .o_cnt(perf_flush));
  hazard_perf_cnt u_perf_memwait (.clk(clk), .rst(rst), .i_en(w_in_wait), .o_cnt(perf_memwait));
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors plus randomized stimulus checked against a cycle model of the hazard rules.
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int MT = 4;
  localparam logic [9:0] PCS = 10'h200, PCR = 10'h100, IFS = 10'h080, IFC = 10'h040, IDS = 10'h020;
  localparam logic [9:0] IDC = 10'h010, EXS = 10'h008, EXC = 10'h004, MS = 10'h002, ERR = 10'h001;
  localparam logic [9:0] ALLS = PCS | IFS | IDS | EXS | MS;
  typedef struct {
    logic rst; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic mr; logic [4:0] rd;
    logic br; logic mq; logic rdy; logic [9:0] exp;
  } vec_t;
  logic clk = 0, rst = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_MemRead = 0, branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic pc_stall, pc_redirect, if_stall, if_clear, id_stall, id_clear, ex_stall, ex_clear, mem_stall, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu, perf_flush, perf_memwait;
`endif
  int checks = 0, errors = 0;
  bit waiting = 0;
  int waited = 0, flush_left = 0, m_lu = 0, m_fl = 0, m_mw = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_stall(pc_stall), .pc_redirect(pc_redirect),
    .if_stall(if_stall), .if_clear(if_clear), .id_stall(id_stall), .id_clear(id_clear),
    .ex_stall(ex_stall), .ex_clear(ex_clear), .mem_stall(mem_stall), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_lu(perf_lu), .perf_flush(perf_flush), .perf_memwait(perf_memwait)
`endif
  );
  function automatic vec_t mk(logic r, logic [4:0] s1, logic [4:0] s2, logic u1, logic u2, logic mr,
                              logic [4:0] rd, logic br, logic mq, logic rdy, logic [9:0] exp);
    vec_t v;
    v.rst = r; v.rs1 = s1; v.rs2 = s2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
    v.br = br; v.mq = mq; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask
  task automatic step(vec_t v, bit use_tbl);
    logic [9:0] e, got;
    int pl, pf, pm;
    bit lu;
    @(negedge clk);
    rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_MemRead = v.mr; ex_rd = v.rd; branch_taken = v.br; mem_req = v.mq; mem_ready = v.rdy;
    #1;
    pl = m_lu; pf = m_fl; pm = m_mw;
    lu = v.mr && v.rd != 0 && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    e = '0;
    if (!v.rst) begin
      e = IFC | IDC | EXC; waiting = 0; flush_left = 0; m_lu = 0; m_fl = 0; m_mw = 0;
    end else if (waiting) begin
      m_mw++;
      if (v.rdy) waiting = 0;
      else if (waited == MT) begin e = ALLS | EXC | ERR; waiting = 0; end
      else begin e = ALLS; waited++; end
    end else if (v.mq && !v.rdy) begin
      e = ALLS; waiting = 1; waited = 1; flush_left = 0;
    end else if (v.br) begin
      e = PCR | IFC | IDC; flush_left = FC - 1; m_fl++;
    end else if (flush_left > 0) begin
      e = IFC | IDC; flush_left--; m_fl++;
    end else if (lu) begin
      e = PCS | IFS | IDC; m_lu++;
    end
    got = {pc_stall, pc_redirect, if_stall, if_clear, id_stall, id_clear, ex_stall, ex_clear, mem_stall, mem_err};
    check(use_tbl ? "table_outputs" : "random_outputs", 32'(got), 32'(use_tbl ? v.exp : e));
`ifdef HAZARD_PERF_EN
    check("perf_lu", perf_lu, 32'(pl));
    check("perf_flush", perf_flush, 32'(pf));
    check("perf_memwait", perf_memwait, 32'(pm));
`else
    if (pl + pf + pm < 0) check("perf_model", 32'(pl), 32'(0));
`endif
  endtask
  initial begin
    vec_t v;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFC | IDC | EXC));
    tbl.push_back(mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, IFC | IDC | EXC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, PCS | IFS | IDC));
    tbl.push_back(mk(1, 5, 0, 1, 0, 0, 5, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 7, 0, 1, 1, 7, 0, 0, 0, PCS | IFS | IDC));
    tbl.push_back(mk(1, 1, 7, 0, 0, 1, 7, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 0, PCR | IFC | IDC));
    tbl.push_back(mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, IFC | IDC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALLS));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, ALLS));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, ALLS));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, PCR | IFC | IDC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFC | IDC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALLS));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALLS | EXC | ERR));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALLS));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALLS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, IFC | IDC | EXC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, PCR | IFC | IDC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALLS));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, PCR | IFC | IDC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, PCR | IFC | IDC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IFC | IDC));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i], 1);
    for (int n = 0; n < 3000; n++) begin
      v = mk($urandom_range(0, 49) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 0);
      step(v, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
